// File: rtl/lcm_req_sched.sv
// Request scheduler in front of the GCD/LCM core: buffers operand pairs in a FIFO,
// drops pairs with a zero operand, and issues one request at a time with a timeout.
module lcm_req_sched #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 300
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vld,
   output logic                     in_rdy,
   input  logic [DATA_W-1:0]        in_a,
   input  logic [DATA_W-1:0]        in_b,
   output logic [DATA_W-1:0]        core_a,
   output logic [DATA_W-1:0]        core_b,
   output logic                     core_vld,
   input  logic                     core_done,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err_zero,
   output logic                     err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

   logic [2*DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wr, r_rd;
   logic [AW:0]         r_cnt;
   state_t              r_state;
   logic [TW-1:0]       r_timer;
   logic                r_gap;
   logic [DATA_W-1:0]   r_core_a, r_core_b;
   logic                r_core_vld, r_err_zero, r_err_to;

   logic                w_push, w_pop, w_zero;
   logic [2*DATA_W-1:0] w_head;

   assign in_rdy = (r_cnt != FULL);
   assign w_push = in_vld && in_rdy;
   assign w_pop  = (r_state == S_IDLE) && (r_cnt != '0);
   assign w_head = r_mem[r_rd];
   assign w_zero = (w_head[2*DATA_W-1:DATA_W] == '0) || (w_head[DATA_W-1:0] == '0);

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {in_a, in_b};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_gap      <= 1'b0;
         r_core_a   <= '0;
         r_core_b   <= '0;
         r_core_vld <= 1'b0;
         r_err_zero <= 1'b0;
         r_err_to   <= 1'b0;
      end else begin
         r_core_vld <= 1'b0;
         r_err_zero <= 1'b0;
         r_err_to   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  if (w_zero) begin
                     r_err_zero <= 1'b1;
                  end else begin
                     r_core_a   <= w_head[2*DATA_W-1:DATA_W];
                     r_core_b   <= w_head[DATA_W-1:0];
                     r_core_vld <= 1'b1;
                     r_timer    <= '0;
                     r_state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A done arriving on the expiry cycle still counts as success.
               if (core_done) begin
                  r_gap   <= 1'b0;
                  r_state <= S_GAP;
               end else if (r_timer == TLAST) begin
                  r_err_to <= 1'b1;
                  r_gap    <= 1'b0;
                  r_state  <= S_GAP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_GAP: begin
               if (r_gap) r_state <= S_IDLE;
               else       r_gap   <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign core_a      = r_core_a;
   assign core_b      = r_core_b;
   assign core_vld    = r_core_vld;
   assign busy        = (r_state != S_IDLE);
   assign level       = r_cnt;
   assign err_zero    = r_err_zero;
   assign err_timeout = r_err_to;

endmodule

// File: tb/tb_lcm_req_sched.sv
// Scenario bench for lcm_req_sched: expected issued pairs are queued at push time
// and compared when core_vld is seen.
module tb_lcm_req_sched;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 300;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } pair_t;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_vld;
   logic                   in_rdy;
   logic [DATA_W-1:0]      in_a, in_b;
   logic [DATA_W-1:0]      core_a, core_b;
   logic                   core_vld;
   logic                   core_done;
   logic                   busy;
   logic [$clog2(DEPTH):0] level;
   logic                   err_zero, err_timeout;

   int checks = 0;
   int errors = 0;
   pair_t exp_q [$];

   int cyc = 0;
   int vld_cnt = 0, dbl_cnt = 0, ez_cnt = 0, et_cnt = 0;
   logic prev_vld = 1'b0;

   lcm_req_sched #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .in_a(in_a), .in_b(in_b), .core_a(core_a), .core_b(core_b),
      .core_vld(core_vld), .core_done(core_done), .busy(busy), .level(level),
      .err_zero(err_zero), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (core_vld) vld_cnt <= vld_cnt + 1;
      if (core_vld && prev_vld) dbl_cnt <= dbl_cnt + 1;
      prev_vld <= core_vld;
      if (err_zero) ez_cnt <= ez_cnt + 1;
      if (err_timeout) et_cnt <= et_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Offers one pair; returns just after the edge that accepted it.
   task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit sb);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (in_rdy) begin
            in_vld = 1'b1; in_a = a; in_b = b;
            @(posedge clk);
            if (sb) exp_q.push_back('{a: a, b: b});
            #1 in_vld = 1'b0;
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         $display("FAIL push_accept pair %0d,%0d not accepted, required accept", a, b);
      end
   endtask

   task automatic wait_vld(input int max, output bit got);
      got = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (core_vld) begin got = 1; break; end
      end
   endtask

   // Caller is between edges; core_done is sampled on the next rising edge.
   task automatic pulse_done();
      core_done = 1'b1;
      @(posedge clk);
      #1 core_done = 1'b0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      ok = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0; core_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (in_rdy !== 1'b1)    begin errors++; $display("FAIL rst_in_rdy got %b exp 1", in_rdy); end
      checks++; if (core_a !== '0)      begin errors++; $display("FAIL rst_core_a got %0d exp 0", core_a); end
      checks++; if (core_b !== '0)      begin errors++; $display("FAIL rst_core_b got %0d exp 0", core_b); end
      checks++; if (core_vld !== 1'b0)  begin errors++; $display("FAIL rst_core_vld got %b exp 0", core_vld); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (level !== '0)       begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
      checks++; if (err_zero !== 1'b0)  begin errors++; $display("FAIL rst_err_zero got %b exp 0", err_zero); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err_timeout got %b exp 0", err_timeout); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      pair_t e;
      bit ok;
      int v0;
      push(8'd12, 8'd18, 1);
      @(negedge clk);
      checks++; if (core_vld !== 1'b0) begin errors++; $display("FAIL single_early_vld got %b exp 0", core_vld); end
      checks++; if (level !== 1)       begin errors++; $display("FAIL single_level got %0d exp 1", level); end
      v0 = vld_cnt;
      @(negedge clk);
      checks++; if (core_vld !== 1'b1) begin errors++; $display("FAIL single_latency core_vld got %b exp 1", core_vld); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb queue empty at issue"); end
      else begin
         e = exp_q.pop_front();
         if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL single_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      repeat (9) @(negedge clk);
      pulse_done();
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap1_busy got %b exp 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap2_busy got %b exp 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", busy); end
      #1;
      checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL single_vld_count got %0d exp 1", vld_cnt - v0); end
      wait_idle(10, ok);
   endtask

   task automatic test_zero_filter();
      pair_t e;
      bit got, ok;
      int v0, z0;
      v0 = vld_cnt; z0 = ez_cnt;
      push(8'd0, 8'd7, 0);
      push(8'd5, 8'd10, 1);
      wait_vld(20, got);
      checks++;
      if (!got) begin errors++; $display("FAIL zero_issue no core_vld, required one"); end
      else if (exp_q.size() == 0) begin errors++; $display("FAIL zero_sb queue empty at issue"); end
      else begin
         e = exp_q.pop_front();
         if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL zero_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      end
      repeat (3) @(negedge clk);
      pulse_done();
      wait_idle(20, ok);
      #1;
      checks++; if (ez_cnt - z0 !== 1)  begin errors++; $display("FAIL zero_err_count got %0d exp 1", ez_cnt - z0); end
      checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL zero_vld_count got %0d exp 1", vld_cnt - v0); end
   endtask

   task automatic test_backpressure();
      pair_t e;
      bit got, ok;
      int v0;
      v0 = vld_cnt;
      for (int i = 1; i <= 5; i++) push(DATA_W'(i), DATA_W'(i + 20), 1);
      repeat (3) @(negedge clk);
      checks++; if (level !== 4)        begin errors++; $display("FAIL bp_level got %0d exp 4", level); end
      checks++; if (in_rdy !== 1'b0)    begin errors++; $display("FAIL bp_in_rdy got %b exp 0", in_rdy); end
      #1;
      checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL bp_vld_count got %0d exp 1", vld_cnt - v0); end
      e = exp_q.pop_front();
      checks++; if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL bp_first got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      fork
         push(8'd6, 8'd26, 1);
      join_none
      @(negedge clk);
      pulse_done();
      for (int k = 0; k < 5; k++) begin
         wait_vld(50, got);
         if (k == 0) begin
            checks++; if (level !== 3)     begin errors++; $display("FAIL bp_pop_level got %0d exp 3", level); end
            checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_pop_in_rdy got %b exp 1", in_rdy); end
         end
         checks++;
         if (!got) begin errors++; $display("FAIL bp_issue_%0d no core_vld, required one", k); end
         else if (exp_q.size() == 0) begin errors++; $display("FAIL bp_sb_%0d queue empty at issue", k); end
         else begin
            e = exp_q.pop_front();
            if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL bp_order_%0d got %0d,%0d exp %0d,%0d", k, core_a, core_b, e.a, e.b); end
         end
         repeat (2) @(negedge clk);
         pulse_done();
      end
      wait_idle(20, ok);
   endtask

   task automatic test_back_to_back();
      pair_t e;
      bit got, ok;
      int v0, done_edge;
      v0 = vld_cnt;
      done_edge = -100;
      push(8'd9, 8'd6, 1);
      for (int k = 0; k < 3; k++) begin
         wait_vld(50, got);
         checks++;
         if (!got) begin errors++; $display("FAIL b2b_issue_%0d no core_vld, required one", k); end
         else begin
            if (cyc - done_edge < 3) begin errors++; $display("FAIL b2b_spacing_%0d got %0d edges exp >=3", k, cyc - done_edge); end
            e = exp_q.pop_front();
            checks++; if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL b2b_pair_%0d got %0d,%0d exp %0d,%0d", k, core_a, core_b, e.a, e.b); end
         end
         if (k == 0) begin
            push(8'd15, 8'd25, 1);
            push(8'd21, 8'd14, 1);
            repeat (2) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         pulse_done();
         done_edge = cyc;
      end
      wait_idle(20, ok);
      repeat (5) @(negedge clk);
      #1;
      checks++; if (vld_cnt - v0 !== 3) begin errors++; $display("FAIL b2b_vld_count got %0d exp 3", vld_cnt - v0); end
   endtask

   task automatic test_timeout();
      pair_t e;
      bit got, ok;
      int t0, iss, tedge, iss2;
      t0 = et_cnt;
      push(8'd3, 8'd4, 1);
      wait_vld(20, got);
      iss = cyc;
      e = exp_q.pop_front();
      checks++; if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL to_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      push(8'd7, 8'd9, 1);
      got = 0;
      for (int i = 0; i < TIMEOUT + 20; i++) begin
         @(negedge clk);
         if (err_timeout) begin got = 1; break; end
      end
      tedge = cyc;
      checks++;
      if (!got) begin errors++; $display("FAIL to_pulse no err_timeout, required one"); end
      else if (tedge - iss !== TIMEOUT) begin errors++; $display("FAIL to_latency got %0d exp %0d", tedge - iss, TIMEOUT); end
      wait_vld(20, got);
      iss2 = cyc;
      checks++; if (!got || iss2 - tedge !== 3) begin errors++; $display("FAIL to_next_issue got %0d edges exp 3", iss2 - tedge); end
      e = exp_q.pop_front();
      checks++; if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL to_next_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      // core_done lands on the exact expiry edge of the second request.
      while (cyc < iss2 + TIMEOUT - 1) @(negedge clk);
      pulse_done();
      wait_idle(10, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++; if (et_cnt - t0 !== 1) begin errors++; $display("FAIL to_err_count got %0d exp 1", et_cnt - t0); end
      checks++; if (!ok) begin errors++; $display("FAIL to_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid();
      pair_t e;
      bit got, ok;
      int v0;
      push(8'd1, 8'd2, 1);
      wait_vld(20, got);
      e = exp_q.pop_front();
      checks++; if (!got || {core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL rm_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      push(8'd3, 8'd4, 1);
      push(8'd5, 8'd6, 1);
      @(negedge clk);
      checks++; if (level !== 2 || busy !== 1'b1) begin errors++; $display("FAIL rm_pre level %0d busy %b exp 2 1", level, busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (level !== '0)     begin errors++; $display("FAIL rm_level got %0d exp 0", level); end
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
      checks++; if (in_rdy !== 1'b1)  begin errors++; $display("FAIL rm_in_rdy got %b exp 1", in_rdy); end
      checks++; if ({core_a, core_b} !== '0) begin errors++; $display("FAIL rm_core_ab got %0d,%0d exp 0,0", core_a, core_b); end
      checks++; if (core_vld !== 1'b0) begin errors++; $display("FAIL rm_core_vld got %b exp 0", core_vld); end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1 v0 = vld_cnt;
      @(negedge clk);
      pulse_done();
      repeat (10) @(negedge clk);
      #1;
      checks++; if (vld_cnt !== v0)  begin errors++; $display("FAIL rm_late_done vld got %0d exp %0d", vld_cnt, v0); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rm_late_busy got %b exp 0", busy); end
      push(8'd8, 8'd12, 1);
      wait_vld(20, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rm_new_issue no core_vld, required one"); end
      else begin
         e = exp_q.pop_front();
         if ({core_a, core_b} !== {e.a, e.b}) begin errors++; $display("FAIL rm_new_pair got %0d,%0d exp %0d,%0d", core_a, core_b, e.a, e.b); end
      end
      repeat (2) @(negedge clk);
      pulse_done();
      wait_idle(10, ok);
   endtask

   initial begin
      test_reset();
      test_single();
      test_zero_filter();
      test_backpressure();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      #1;
      checks++; if (dbl_cnt !== 0) begin errors++; $display("FAIL vld_consecutive got %0d exp 0", dbl_cnt); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
